// File: rtl/combo_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : combo_lock_ctrl
// Purpose  : Combination-lock controller. Stores a KEY_W-bit secret, checks
//            attempts against it, limits wrong attempts, enforces an unlock
//            timeout and a timed (or permanent) lockout. Drives lock/alert
//            indicators and BCD counts for two external 7-segment digits.
// Revision : 1.0 - initial release
// ============================================================================
module combo_lock_ctrl #(
    parameter int KEY_W     = 4,
    parameter int MAX_TRIES = 5,
    parameter int TIMEOUT_S = 9,
    parameter int LOCKOUT_S = 9,
    parameter int TICK_DIV  = 100000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] key_in,
    input  logic             set_key,
    input  logic             cmp,
    input  logic             relock,
    output logic             open,
    output logic             locked,
    output logic             alert,
    output logic [3:0]       tries_left,
    output logic [3:0]       time_left
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter range checks
    // ------------------------------------------------------------------------
    if (KEY_W < 1 || KEY_W > 16) begin : g_bad_key_w
        $error("combo_lock_ctrl: KEY_W must be in 1..16");
    end
    if (MAX_TRIES < 1 || MAX_TRIES > 15) begin : g_bad_max_tries
        $error("combo_lock_ctrl: MAX_TRIES must be in 1..15");
    end
    if (TIMEOUT_S < 1 || TIMEOUT_S > 15) begin : g_bad_timeout
        $error("combo_lock_ctrl: TIMEOUT_S must be in 1..15");
    end
    if (LOCKOUT_S < 0 || LOCKOUT_S > 15) begin : g_bad_lockout
        $error("combo_lock_ctrl: LOCKOUT_S must be in 0..15");
    end
    if (TICK_DIV < 2) begin : g_bad_tick_div
        $error("combo_lock_ctrl: TICK_DIV must be >= 2");
    end

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_ST_UNSET = 2'd0;
    localparam logic [1:0] c_ST_ARMED = 2'd1;
    localparam logic [1:0] c_ST_OPEN  = 2'd2;
    localparam logic [1:0] c_ST_ALERT = 2'd3;

    localparam int              c_CNT_W     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_TICK_LAST = c_CNT_W'(TICK_DIV - 1);
    localparam logic [3:0]      c_MAX_TRIES = 4'(MAX_TRIES);
    localparam logic [3:0]      c_TIMEOUT   = 4'(TIMEOUT_S);
    localparam logic [3:0]      c_LOCKOUT   = 4'(LOCKOUT_S);
    localparam bit              c_LOCK_RUNS = (LOCKOUT_S > 0);

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [KEY_W-1:0]   r_key;
    logic [3:0]         r_tries;
    logic [3:0]         r_time;
    logic [c_CNT_W-1:0] r_tick_cnt;
    logic               r_set_q;
    logic               r_cmp_q;
    logic               r_relock_q;
    logic               r_open;
    logic               r_locked;
    logic               r_alert;

    logic [1:0]         w_state_nxt;
    logic [KEY_W-1:0]   w_key_nxt;
    logic [3:0]         w_tries_nxt;
    logic [3:0]         w_time_nxt;
    logic [3:0]         w_tries_dec;
    logic [3:0]         w_time_dec;
    logic               w_set_ev;
    logic               w_cmp_ev;
    logic               w_relock_ev;
    logic               w_match;
    logic               w_run;
    logic               w_tick;
    logic               w_open_nxt;
    logic               w_alert_nxt;

    // Single-event edge detection on the level inputs
    assign w_set_ev    = set_key & ~r_set_q;
    assign w_cmp_ev    = cmp     & ~r_cmp_q;
    assign w_relock_ev = relock  & ~r_relock_q;

    assign w_match     = (key_in == r_key);
    assign w_tries_dec = (r_tries == 4'd0) ? 4'd0 : r_tries - 4'd1;
    assign w_time_dec  = (r_time  == 4'd0) ? 4'd0 : r_time  - 4'd1;

    // The seconds prescaler only runs while a countdown is visible
    assign w_run  = (r_state == c_ST_ARMED) ||
                    ((r_state == c_ST_ALERT) && c_LOCK_RUNS);
    assign w_tick = w_run && (r_tick_cnt == c_TICK_LAST);

    // Input edge registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_set_q    <= 1'b0;
            r_cmp_q    <= 1'b0;
            r_relock_q <= 1'b0;
        end else begin
            r_set_q    <= set_key;
            r_cmp_q    <= cmp;
            r_relock_q <= relock;
        end
    end

    // Seconds prescaler: restarts on every state entry so each state gets full seconds
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt <= '0;
        end else if ((w_state_nxt != r_state) || !w_run || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + c_CNT_W'(1);
        end
    end

    // State register together with key and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_UNSET;
            r_key   <= '0;
            r_tries <= c_MAX_TRIES;
            r_time  <= c_TIMEOUT;
        end else begin
            r_state <= w_state_nxt;
            r_key   <= w_key_nxt;
            r_tries <= w_tries_nxt;
            r_time  <= w_time_nxt;
        end
    end

    // Next-state and counter update; in ARMED the attempt is judged before the tick
    always_comb begin
        w_state_nxt = r_state;
        w_key_nxt   = r_key;
        w_tries_nxt = r_tries;
        w_time_nxt  = r_time;
        case (r_state)
            c_ST_UNSET: begin
                if (w_set_ev) begin
                    w_key_nxt   = key_in;
                    w_state_nxt = c_ST_ARMED;
                    w_tries_nxt = c_MAX_TRIES;
                    w_time_nxt  = c_TIMEOUT;
                end
            end
            c_ST_ARMED: begin
                if (w_cmp_ev && w_match) begin
                    // Time display freezes at its current value while open
                    w_state_nxt = c_ST_OPEN;
                    w_tries_nxt = c_MAX_TRIES;
                end else begin
                    if (w_cmp_ev) begin
                        w_tries_nxt = w_tries_dec;
                    end
                    if ((w_cmp_ev && (w_tries_dec == 4'd0)) ||
                        (w_tick && (w_time_dec == 4'd0))) begin
                        w_state_nxt = c_ST_ALERT;
                        w_time_nxt  = c_LOCKOUT;
                    end else if (w_tick) begin
                        w_time_nxt  = w_time_dec;
                    end
                end
            end
            c_ST_OPEN: begin
                // A new key takes priority over a plain relock
                if (w_set_ev) begin
                    w_key_nxt   = key_in;
                    w_state_nxt = c_ST_ARMED;
                    w_tries_nxt = c_MAX_TRIES;
                    w_time_nxt  = c_TIMEOUT;
                end else if (w_relock_ev) begin
                    w_state_nxt = c_ST_ARMED;
                    w_tries_nxt = c_MAX_TRIES;
                    w_time_nxt  = c_TIMEOUT;
                end
            end
            c_ST_ALERT: begin
                // w_tick never fires here for a permanent lockout
                if (w_tick) begin
                    if (w_time_dec == 4'd0) begin
                        w_state_nxt = c_ST_ARMED;
                        w_tries_nxt = c_MAX_TRIES;
                        w_time_nxt  = c_TIMEOUT;
                    end else begin
                        w_time_nxt  = w_time_dec;
                    end
                end
            end
            default: begin
                w_state_nxt = c_ST_UNSET;
            end
        endcase
    end

    // Indicator decode from the upcoming state
    always_comb begin
        w_open_nxt  = (w_state_nxt == c_ST_OPEN);
        w_alert_nxt = (w_state_nxt == c_ST_ALERT);
    end

    // Indicator registers so the outputs change on the same edge as the state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_open   <= 1'b0;
            r_locked <= 1'b1;
            r_alert  <= 1'b0;
        end else begin
            r_open   <= w_open_nxt;
            r_locked <= ~w_open_nxt;
            r_alert  <= w_alert_nxt;
        end
    end

    assign open       = r_open;
    assign locked     = r_locked;
    assign alert      = r_alert;
    assign tries_left = r_tries;
    assign time_left  = r_time;

endmodule
`default_nettype wire

// File: tb/tb_combo_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_combo_lock_ctrl
// Purpose  : Self-checking bench for combo_lock_ctrl: a directed vector table,
//            hand-written corner sequences and randomized traffic compared
//            against a behavioural model each clock.
// Revision : 1.0 - initial release
// ============================================================================
module tb_combo_lock_ctrl;

    localparam int P_KEY_W = 4;
    localparam int P_MAX   = 3;
    localparam int P_TOUT  = 5;
    localparam int P_LOCK  = 2;
    localparam int P_DIV   = 4;

    logic             clk;
    logic             rst;
    logic [P_KEY_W-1:0] key_in;
    logic             set_key;
    logic             cmp;
    logic             relock;
    logic             open;
    logic             locked;
    logic             alert;
    logic [3:0]       tries_left;
    logic [3:0]       time_left;

    int n_checks;
    int n_errors;

    combo_lock_ctrl #(
        .KEY_W     (P_KEY_W),
        .MAX_TRIES (P_MAX),
        .TIMEOUT_S (P_TOUT),
        .LOCKOUT_S (P_LOCK),
        .TICK_DIV  (P_DIV)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .set_key    (set_key),
        .cmp        (cmp),
        .relock     (relock),
        .open       (open),
        .locked     (locked),
        .alert      (alert),
        .tries_left (tries_left),
        .time_left  (time_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Behavioural model: mode plus "cycles spent in mode"; displayed time is
    // derived arithmetically as base minus elapsed whole seconds.
    // ------------------------------------------------------------------------
    localparam int M_UNSET = 10;
    localparam int M_ARMED = 20;
    localparam int M_OPEN  = 30;
    localparam int M_ALERT = 40;

    int m_mode, m_key, m_tries, m_base, m_cyc;
    bit p_set, p_cmp, p_rel;

    function automatic int m_time();
        if ((m_mode == M_ARMED) || (m_mode == M_ALERT && P_LOCK > 0))
            return m_base - m_cyc / P_DIV;
        return m_base;
    endfunction

    task automatic m_rearm();
        m_mode  = M_ARMED;
        m_tries = P_MAX;
        m_base  = P_TOUT;
        m_cyc   = 0;
    endtask

    task automatic model_step(input int r, input int k, input int s, input int c, input int rl);
        bit ev_s, ev_c, ev_r, due;
        int cur, nt;
        if (r != 0) begin
            m_mode = M_UNSET; m_key = 0; m_tries = P_MAX; m_base = P_TOUT; m_cyc = 0;
            p_set = 0; p_cmp = 0; p_rel = 0;
            return;
        end
        ev_s = (s != 0) && !p_set;
        ev_c = (c != 0) && !p_cmp;
        ev_r = (rl != 0) && !p_rel;
        p_set = (s != 0); p_cmp = (c != 0); p_rel = (rl != 0);
        cur = m_time();
        due = ((m_cyc % P_DIV) == P_DIV - 1);
        case (m_mode)
            M_UNSET: if (ev_s) begin m_key = k; m_rearm(); end
            M_ARMED: begin
                if (ev_c && k == m_key) begin
                    m_mode = M_OPEN; m_tries = P_MAX; m_base = cur; m_cyc = 0;
                end else begin
                    nt = due ? cur - 1 : cur;
                    if (ev_c) m_tries = m_tries - 1;
                    if (m_tries == 0 || nt == 0) begin
                        m_mode = M_ALERT; m_base = P_LOCK; m_cyc = 0;
                    end else begin
                        m_cyc++;
                    end
                end
            end
            M_OPEN: begin
                if (ev_s) begin m_key = k; m_rearm(); end
                else if (ev_r) m_rearm();
            end
            default: begin
                if (P_LOCK > 0) begin
                    nt = due ? cur - 1 : cur;
                    if (nt == 0) m_rearm();
                    else m_cyc++;
                end
            end
        endcase
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("model open",   int'(open),       int'(m_mode == M_OPEN));
        chk("model locked", int'(locked),     int'(m_mode != M_OPEN));
        chk("model alert",  int'(alert),      int'(m_mode == M_ALERT));
        chk("model tries",  int'(tries_left), m_tries);
        chk("model time",   int'(time_left),  m_time());
    endtask

    // One clock: drive inputs, let the edge pass, advance model, compare #1 later
    task automatic step(input int r, input int k, input int s, input int c, input int rl);
        rst     = (r != 0);
        key_in  = P_KEY_W'(k);
        set_key = (s != 0);
        cmp     = (c != 0);
        relock  = (rl != 0);
        @(posedge clk);
        model_step(r, k, s, c, rl);
        #1;
        check_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    // ------------------------------------------------------------------------
    // Directed vector table: inputs for one cycle and outputs after that edge
    // ------------------------------------------------------------------------
    typedef struct {
        int r, k, s, c, rl;
        int e_open, e_alert, e_tries, e_time;
    } vec_t;

    vec_t tbl[25];

    initial begin
        int pr_s, pr_c, pr_r, kk;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1; key_in = '0; set_key = 1'b0; cmp = 1'b0; relock = 1'b0;
        m_mode = M_UNSET; m_key = 0; m_tries = P_MAX; m_base = P_TOUT; m_cyc = 0;
        p_set = 0; p_cmp = 0; p_rel = 0;

        tbl[0]  = '{1, 0, 0,0,0, 0,0,3,5};   // reset
        tbl[1]  = '{0,10, 1,0,0, 0,0,3,5};   // set key A -> ARMED
        tbl[2]  = '{0,10, 0,0,0, 0,0,3,5};
        tbl[3]  = '{0,10, 0,1,0, 1,0,3,5};   // match -> OPEN
        tbl[4]  = '{0,10, 0,0,0, 1,0,3,5};
        tbl[5]  = '{0,10, 0,0,1, 0,0,3,5};   // relock, key kept
        tbl[6]  = '{0, 5, 0,1,0, 0,0,2,5};   // wrong key
        tbl[7]  = '{0, 5, 0,1,0, 0,0,2,5};   // held level, no event
        tbl[8]  = '{0, 3, 0,0,0, 0,0,2,5};
        tbl[9]  = '{0, 3, 0,1,0, 0,0,1,4};   // wrong key on a tick
        tbl[10] = '{0, 3, 0,0,0, 0,0,1,4};
        tbl[11] = '{0, 3, 0,1,0, 0,1,0,2};   // last try -> ALERT
        tbl[12] = '{0, 3, 0,0,0, 0,1,0,2};
        tbl[13] = '{0, 3, 0,1,0, 0,1,0,2};   // ignored in ALERT
        tbl[14] = '{0, 3, 0,0,0, 0,1,0,2};
        tbl[15] = '{0, 3, 0,0,0, 0,1,0,1};
        tbl[16] = '{0, 3, 0,0,0, 0,1,0,1};
        tbl[17] = '{0, 3, 0,0,0, 0,1,0,1};
        tbl[18] = '{0, 3, 0,0,0, 0,1,0,1};
        tbl[19] = '{0, 3, 0,0,0, 0,0,3,5};   // lockout over -> ARMED
        tbl[20] = '{0,10, 0,1,0, 1,0,3,5};   // key A still valid
        tbl[21] = '{0, 5, 1,0,0, 0,0,3,5};   // rekey to 5
        tbl[22] = '{0, 5, 0,1,0, 1,0,3,5};
        tbl[23] = '{1, 5, 0,0,0, 0,0,3,5};   // reset
        tbl[24] = '{0, 0, 0,1,0, 0,0,3,5};   // cmp ignored in UNSET

        for (int i = 0; i < 25; i++) begin
            step(tbl[i].r, tbl[i].k, tbl[i].s, tbl[i].c, tbl[i].rl);
            chk($sformatf("vec%0d open", i),   int'(open),       tbl[i].e_open);
            chk($sformatf("vec%0d locked", i), int'(locked),     1 - tbl[i].e_open);
            chk($sformatf("vec%0d alert", i),  int'(alert),      tbl[i].e_alert);
            chk($sformatf("vec%0d tries", i),  int'(tries_left), tbl[i].e_tries);
            chk($sformatf("vec%0d time", i),   int'(time_left),  tbl[i].e_time);
        end

        // Timeout then timed lockout
        step(1, 0, 0, 0, 0);
        step(0, 10, 1, 0, 0);
        idle(19);
        chk("timeout pre alert", int'(alert), 0);
        chk("timeout pre time", int'(time_left), 1);
        idle(1);
        chk("timeout alert", int'(alert), 1);
        chk("timeout lock time", int'(time_left), 2);
        chk("timeout tries kept", int'(tries_left), 3);
        idle(7);
        chk("lockout still", int'(alert), 1);
        idle(1);
        chk("lockout over alert", int'(alert), 0);
        chk("lockout over tries", int'(tries_left), 3);
        chk("lockout over time", int'(time_left), 5);

        // Match on the final timeout tick wins
        step(1, 0, 0, 0, 0);
        step(0, 10, 1, 0, 0);
        idle(19);
        step(0, 10, 0, 1, 0);
        chk("final tick match open", int'(open), 1);
        chk("final tick match alert", int'(alert), 0);

        // Relock, then a wrong key held high for 10 cycles counts once
        step(0, 10, 0, 0, 1);
        chk("relock locked", int'(locked), 1);
        for (int i = 0; i < 10; i++) step(0, 3, 0, 1, 0);
        chk("held cmp tries", int'(tries_left), 2);
        step(0, 3, 0, 0, 0);
        step(0, 3, 0, 1, 0);
        step(0, 3, 0, 0, 0);
        step(0, 3, 0, 1, 0);
        chk("tries alert", int'(alert), 1);
        chk("tries zero", int'(tries_left), 0);

        // Reset during ALERT mid-tick
        idle(2);
        step(1, 3, 0, 0, 0);
        chk("rst alert", int'(alert), 0);
        chk("rst locked", int'(locked), 1);
        chk("rst tries", int'(tries_left), 3);
        chk("rst time", int'(time_left), 5);
        step(0, 0, 0, 1, 0);
        chk("unset cmp open", int'(open), 0);
        chk("unset cmp tries", int'(tries_left), 3);

        // Randomized traffic against the model
        pr_s = 0; pr_c = 0; pr_r = 0;
        for (int i = 0; i < 4000; i++) begin
            case ($urandom_range(0, 3))
                0: kk = 10;
                1: kk = 5;
                2: kk = 3;
                default: kk = int'($urandom_range(0, 15));
            endcase
            if ($urandom_range(0, 4) == 0) pr_s = 1 - pr_s;
            if ($urandom_range(0, 2) == 0) pr_c = 1 - pr_c;
            if ($urandom_range(0, 5) == 0) pr_r = 1 - pr_r;
            step(($urandom_range(0, 199) == 0) ? 1 : 0, kk, pr_s, pr_c, pr_r);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
